// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and default sizing for the round-robin grant arbiter slice.
//   arb_state_t   : arbiter FSM state (IDLE = nothing granted, GRANT = held)
//   ARB_IN        : default number of requesters
//   ARB_OUT       : default grant index width, $clog2(ARB_IN)
//   ARB_MAX_HOLD  : default longest run of consecutive grant cycles
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int ARB_IN       = 8;
  localparam int ARB_OUT      = 3;
  localparam int ARB_MAX_HOLD = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_grant_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_grant_arbiter_if
// Request/grant bundle between the requesters and the arbiter.
//   req        : request vector, bit k = requester k (requester side drives)
//   gnt        : one-hot grant, all-zero when idle (arbiter drives)
//   gnt_id     : binary index of the granted requester (arbiter drives)
//   gnt_valid  : high while a grant is held (arbiter drives)
// Modports: master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface rr_grant_arbiter_if
  import arb_pkg::*;
#(
  parameter int IN  = ARB_IN,
  parameter int OUT = ARB_OUT
);

  logic [IN-1:0]  req;
  logic [IN-1:0]  gnt;
  logic [OUT-1:0] gnt_id;
  logic           gnt_valid;

  modport master (output req, input gnt, input gnt_id, input gnt_valid);
  modport slave  (input req, output gnt, output gnt_id, output gnt_valid);

endinterface

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin winner selection.
//   req        in   IN   request vector
//   ptr        in   OUT  index holding highest priority this round
//   any        out  1    at least one request is set
//   winner_oh  out  IN   one-hot winner (zero when no request)
//   winner_id  out  OUT  binary winner index (zero when no request)
// The circular search starting at ptr is done as a masked priority search:
// the lowest set bit at or above ptr wins, otherwise the lowest set bit
// overall (which is the wrap-around part of the circle).
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int IN  = 8,
  parameter int OUT = 3
) (
  input  logic [IN-1:0]  req,
  input  logic [OUT-1:0] ptr,
  output logic           any,
  output logic [IN-1:0]  winner_oh,
  output logic [OUT-1:0] winner_id
);

  logic [IN-1:0] upper_mask;
  logic [IN-1:0] masked;
  logic [IN-1:0] cand;

  assign any = |req;

  // Build the "at or above ptr" mask, choose which request set to search,
  // then take its lowest set bit by scanning from the top down so the last
  // hit (the lowest index) is the one that sticks.
  always_comb begin
    upper_mask = '0;
    for (int k = 0; k < IN; k++) begin
      upper_mask[k] = (k >= int'(ptr));
    end
    masked = req & upper_mask;
    cand   = (|masked) ? masked : req;

    winner_id = '0;
    for (int k = IN - 1; k >= 0; k--) begin
      if (cand[k]) begin
        winner_id = OUT'(k);
      end
    end

    winner_oh = '0;
    for (int k = 0; k < IN; k++) begin
      winner_oh[k] = cand[k] && (winner_id == OUT'(k));
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// ---------------------------------------------------------------------------
// rr_grant_arbiter
// Round-robin arbiter sharing one resource among IN requesters. One grant at
// a time, held until the owner drops its request or MAX_HOLD cycles pass,
// then priority rotates to the requester just past the winner. There is
// always one idle cycle between consecutive grants.
//   clk   in   1    clock, rising edge
//   rst   in   1    synchronous reset, active-high
//   bus   slave modport of rr_grant_arbiter_if
//         (req in; gnt, gnt_id, gnt_valid out, all registered)
// ---------------------------------------------------------------------------
module rr_grant_arbiter
  import arb_pkg::*;
#(
  parameter int IN       = ARB_IN,
  parameter int OUT      = ARB_OUT,
  parameter int MAX_HOLD = ARB_MAX_HOLD
) (
  input logic               clk,
  input logic               rst,
  rr_grant_arbiter_if.slave bus
);

  localparam int             HW        = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [OUT-1:0] LAST_ID   = OUT'(IN - 1);

  arb_state_t     state;
  arb_state_t     state_nx;
  logic [OUT-1:0] ptr;
  logic [OUT-1:0] ptr_nx;
  logic [HW-1:0]  hold_cnt;
  logic [HW-1:0]  hold_nx;
  logic [IN-1:0]  gnt_q;
  logic [IN-1:0]  gnt_nx;
  logic [OUT-1:0] id_q;
  logic [OUT-1:0] id_nx;
  logic           valid_q;
  logic           valid_nx;

  logic           pick_any;
  logic [IN-1:0]  pick_oh;
  logic [OUT-1:0] pick_id;
  logic           release_now;

  rr_pick #(
    .IN  (IN),
    .OUT (OUT)
  ) u_pick (
    .req       (bus.req),
    .ptr       (ptr),
    .any       (pick_any),
    .winner_oh (pick_oh),
    .winner_id (pick_id)
  );

  // The owner's request bit is found by masking req with the one-hot grant,
  // which avoids indexing req with gnt_id. Only meaningful in GRANT.
  assign release_now = ~|(bus.req & gnt_q) | (hold_cnt == HOLD_LAST);

  // State and all datapath registers. Reset wins over everything, including
  // a grant that is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt_q    <= '0;
      id_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
      gnt_q    <= gnt_nx;
      id_q     <= id_nx;
      valid_q  <= valid_nx;
    end
  end

  // Next-state: leave IDLE on any request, leave GRANT on release/timeout.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_any)    state_nx = GRANT;
      GRANT:   if (release_now) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values for the registered outputs, pointer and hold counter.
  // On release the pointer moves just past the owner so a requester that
  // timed out drops to lowest priority for the next arbitration.
  always_comb begin
    gnt_nx   = gnt_q;
    id_nx    = id_q;
    valid_nx = valid_q;
    ptr_nx   = ptr;
    hold_nx  = hold_cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          gnt_nx   = pick_oh;
          id_nx    = pick_id;
          valid_nx = 1'b1;
          hold_nx  = '0;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_nx   = '0;
          id_nx    = '0;
          valid_nx = 1'b0;
          hold_nx  = '0;
          ptr_nx   = (id_q == LAST_ID) ? '0 : id_q + 1'b1;
        end else begin
          hold_nx = hold_cnt + 1'b1;
        end
      end
      default: begin
        gnt_nx   = '0;
        id_nx    = '0;
        valid_nx = 1'b0;
        hold_nx  = '0;
      end
    endcase
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = valid_q;

endmodule
